renode_interrupts_receiver: RTL and testbench

//   Renode-to-HDL counterpart of the interrupt sender: accepts interrupt messages

---
 rtl/renode_interrupts_receiver.sv | 128 ++++++++++++
 tb/tb_renode_interrupts_receiver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/renode_interrupts_receiver.sv
// Receives Renode interrupt messages, buffers them in a small FIFO, drives the
// per-line outputs and answers each message with an OK/ERROR response.
module renode_interrupts_receiver #(
    parameter int unsigned                InterruptsCount = 1,
    parameter int unsigned                FifoDepth       = 4,
    parameter logic [InterruptsCount-1:0] LinesResetValue = '0,
    parameter logic [7:0]                 ActionInterrupt = 8'd20,
    parameter logic [7:0]                 ActionOk        = 8'd1,
    parameter logic [7:0]                 ActionError     = 8'd2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [7:0]                 req_action,
    input  logic [63:0]                req_addr,
    input  logic [63:0]                req_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [7:0]                 rsp_action,
    output logic [63:0]                rsp_addr,
    output logic [63:0]                rsp_data,
    output logic [InterruptsCount-1:0] interrupts,
    output logic [InterruptsCount-1:0] line_event,
    output logic [15:0]                error_count
);
    localparam int unsigned AW = $clog2(FifoDepth);

    typedef struct packed {
        logic [7:0]  action;
        logic [63:0] addr;
        logic [63:0] data;
    } msg_t;

    typedef enum logic {IDLE, RESP} state_e;

    msg_t                       mem_q [FifoDepth];
    logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [AW:0]                count_q, count_d;
    state_e                     state_q, state_d;
    logic                       rsp_valid_q, rsp_valid_d;
    msg_t                       rsp_q, rsp_d;
    logic [InterruptsCount-1:0] lines_q, lines_d, event_q;
    logic [15:0]                err_q, err_d;
    msg_t                       head;
    logic                       empty, full, push, pop, ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(FifoDepth));
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign head      = mem_q[rd_ptr_q];
    assign ok        = (head.action == ActionInterrupt) && (head.data < 64'(InterruptsCount));

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        lines_d     = lines_q;
        err_d       = err_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                state_d = RESP;
            end
            RESP: if (rsp_ready) begin
                // Chaining the next pop onto the handshake keeps one message per cycle.
                if (!empty) pop = 1'b1;
                else begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            rsp_valid_d = 1'b1;
            rsp_d.addr  = head.addr;
            rsp_d.data  = head.data;
            if (ok) begin
                rsp_d.action = ActionOk;
                for (int i = 0; i < InterruptsCount; i++)
                    if (head.data == 64'(i)) lines_d[i] = head.addr[0];
            end else begin
                rsp_d.action = ActionError;
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            end
        end
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{req_action, req_addr, req_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            lines_q     <= LinesResetValue;
            event_q     <= '0;
            err_q       <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q     <= count_d;
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            lines_q     <= lines_d;
            event_q     <= lines_d ^ lines_q;
            err_q       <= err_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_action  = rsp_q.action;
    assign rsp_addr    = rsp_q.addr;
    assign rsp_data    = rsp_q.data;
    assign interrupts  = lines_q;
    assign line_event  = event_q;
    assign error_count = err_q;
endmodule

// File: tb/tb_renode_interrupts_receiver.sv
// Bench for renode_interrupts_receiver: table vectors, a stalled burst and a
// mid-traffic reset, all checked through a response scoreboard.
module tb_renode_interrupts_receiver;
    localparam logic [7:0] A_INT = 8'd20, A_OK = 8'd1, A_ERR = 8'd2;

    logic        clk = 1'b0, rst;
    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [7:0]  req_action, rsp_action;
    logic [63:0] req_addr, req_data, rsp_addr, rsp_data;
    logic [3:0]  interrupts, line_event;
    logic [15:0] error_count;

    renode_interrupts_receiver #(
        .InterruptsCount(4), .FifoDepth(4), .LinesResetValue(4'b0101),
        .ActionInterrupt(A_INT), .ActionOk(A_OK), .ActionError(A_ERR)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_action(req_action),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_action(rsp_action),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .interrupts(interrupts), .line_event(line_event), .error_count(error_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  act;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  ract;
        logic [3:0]  lines;
        logic [3:0]  ev;
        logic [15:0] err;
    } vec_t;

    typedef struct {
        logic [7:0]  ract;
        logic [63:0] addr;
        logic [63:0] data;
        logic [3:0]  lines;
        logic        chk_ev;
        logic [3:0]  ev;
        logic [15:0] err;
    } exp_t;

    exp_t       sb[$];
    int         hs_times[$];
    int         checks = 0, errors = 0, cyc = 0;
    logic [3:0] m_lines = 4'b0101;
    logic [15:0] m_err = 16'd0;
    vec_t       vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    function automatic exp_t predict(input logic [7:0] act, input logic [63:0] addr,
                                     input logic [63:0] data);
        exp_t e;
        e.addr = addr; e.data = data; e.chk_ev = 1'b0; e.ev = '0;
        if (act == A_INT && data < 64'd4) begin
            m_lines[data[1:0]] = addr[0];
            e.ract = A_OK;
        end else begin
            e.ract = A_ERR;
            m_err = m_err + 16'd1;
        end
        e.lines = m_lines; e.err = m_err;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            hs_times.push_back(cyc);
            if (sb.size() == 0) chk("unexpected_rsp", {56'd0, rsp_action}, 64'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_action", {56'd0, rsp_action}, {56'd0, e.ract});
                chk("rsp_addr", rsp_addr, e.addr);
                chk("rsp_data", rsp_data, e.data);
                chk("interrupts", {60'd0, interrupts}, {60'd0, e.lines});
                chk("error_count", {48'd0, error_count}, {48'd0, e.err});
                if (e.chk_ev) chk("line_event", {60'd0, line_event}, {60'd0, e.ev});
            end
        end
    end

    task automatic send(input logic [7:0] act, input logic [63:0] addr,
                        input logic [63:0] data, input exp_t e);
        bit acc = 0;
        req_valid = 1'b1; req_action = act; req_addr = addr; req_data = data;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (req_ready) begin
                sb.push_back(e);
                acc = 1;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n0;
        vecs[0] = '{A_INT, 64'd1, 64'd1, A_OK,  4'b0111, 4'b0010, 16'd0};
        vecs[1] = '{A_INT, 64'd0, 64'd2, A_OK,  4'b0011, 4'b0100, 16'd0};
        vecs[2] = '{A_INT, 64'd1, 64'd3, A_OK,  4'b1011, 4'b1000, 16'd0};
        vecs[3] = '{A_INT, 64'd1, 64'd7, A_ERR, 4'b1011, 4'b0000, 16'd1};
        vecs[4] = '{8'd99, 64'd1, 64'd0, A_ERR, 4'b1011, 4'b0000, 16'd2};
        vecs[5] = '{A_INT, 64'h1_0000_0000, 64'd0, A_OK, 4'b1010, 4'b0001, 16'd2};
        vecs[6] = '{A_INT, 64'd1, 64'd0, A_OK,  4'b1011, 4'b0001, 16'd2};
        vecs[7] = '{A_INT, 64'd1, 64'd0, A_OK,  4'b1011, 4'b0000, 16'd2};
        vecs[8] = '{A_INT, 64'd1, 64'h1_0000_0001, A_ERR, 4'b1011, 4'b0000, 16'd3};
        vecs[9] = '{A_INT, 64'd3, 64'd3, A_OK,  4'b1011, 4'b0000, 16'd3};

        rst = 1'b1; req_valid = 1'b0; req_action = '0; req_addr = '0; req_data = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_interrupts", {60'd0, interrupts}, 64'h5);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_error_count", {48'd0, error_count}, 64'd0);
        chk("rst_line_event", {60'd0, line_event}, 64'd0);
        rst = 1'b0;

        // Table vectors, one message at a time with the response channel open.
        for (int i = 0; i < 10; i++) begin
            e = '{vecs[i].ract, vecs[i].addr, vecs[i].data, vecs[i].lines, 1'b1,
                  vecs[i].ev, vecs[i].err};
            m_lines = vecs[i].lines; m_err = vecs[i].err;
            send(vecs[i].act, vecs[i].addr, vecs[i].data, e);
            wait_drain();
        end

        // Stalled burst: responses held back until the FIFO fills.
        rsp_ready = 1'b0;
        n0 = hs_times.size();
        for (int i = 0; i < 5; i++) begin
            logic [63:0] a, d;
            a = 64'((i + 1) % 2); d = 64'(i % 4);
            e = predict(A_INT, a, d);
            send(A_INT, a, d, e);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_req_ready", {63'd0, req_ready}, 64'd0);
            chk("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("stall_rsp_data", rsp_data, 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_drain();
        chk("burst_count", 64'(hs_times.size() - n0), 64'd5);
        if (hs_times.size() == n0 + 5)
            chk("burst_back_to_back", 64'(hs_times[n0+4] - hs_times[n0]), 64'd4);
        chk("burst_req_ready", {63'd0, req_ready}, 64'd1);

        // Reset with one pending response and three buffered messages.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = predict(A_INT, 64'd0, 64'(i));
            send(A_INT, 64'd0, 64'(i), e);
        end
        @(negedge clk);
        chk("pre_rst_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        sb.delete();
        m_lines = 4'b0101; m_err = 16'd0;
        chk("mid_rst_interrupts", {60'd0, interrupts}, 64'h5);
        chk("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mid_rst_rsp_data", rsp_data, 64'd0);
        chk("mid_rst_rsp_action", {56'd0, rsp_action}, 64'd0);
        chk("mid_rst_line_event", {60'd0, line_event}, 64'd0);
        chk("mid_rst_error_count", {48'd0, error_count}, 64'd0);
        chk("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        n0 = hs_times.size();
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_rsp", 64'(hs_times.size() - n0), 64'd0);
        chk("post_rst_interrupts", {60'd0, interrupts}, 64'h5);

        // A fresh message after reset still works.
        e = predict(A_INT, 64'd1, 64'd3);
        e.chk_ev = 1'b1; e.ev = 4'b1000;
        send(A_INT, 64'd1, 64'd3, e);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
